// File: rtl/qoa_pkg.sv
// rtl/qoa_pkg.sv - shared opcodes, FSM encoding and constants for the QOA command sequencer
package qoa_pkg;

    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_LMS = 8'h01;
    localparam logic [7:0] OP_DEC = 8'h02;
    localparam logic [7:0] OP_CLR = 8'h03;

    // Top bit of every status byte, so the host can tell status from sample data framing
    localparam logic STATUS_MARKER = 1'b1;

    localparam int SAMPLE_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LMS,
        ST_SLICE,
        ST_START
    } qoa_state_e;

endpackage

// File: rtl/qoa_sample_fifo.sv
// rtl/qoa_sample_fifo.sv - synchronous sample FIFO between decoder and SPI TX scheduler
module qoa_sample_fifo
    import qoa_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                push_i,
    input  logic                pop_i,
    input  logic [SAMPLE_W-1:0] din_i,
    output logic [SAMPLE_W-1:0] dout_o,
    output logic                full_o,
    output logic                empty_o,
    output logic [CW-1:0]       count_o
);

    logic [SAMPLE_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]       wptr_q, rptr_q;
    logic [CW-1:0]       count_q;
    logic                push_ok, pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rptr_q];

    // Requests against a full/empty FIFO are ignored rather than corrupting pointers
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Storage array; unreset because contents are only read when count says valid
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wptr_q] <= din_i;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave the count unchanged
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + AW'(1);
            if (pop_ok)  rptr_q <= rptr_q + AW'(1);
            if (push_ok && !pop_ok) begin
                count_q <= count_q + CW'(1);
            end else if (pop_ok && !push_ok) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

endmodule

// File: rtl/qoa_cmd_sequencer.sv
// rtl/qoa_cmd_sequencer.sv - SPI byte command parser, decoder starter and sample TX scheduler
module qoa_cmd_sequencer
    import qoa_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int LMS_BYTES   = 16,
    parameter int SLICE_BYTES = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                cs_active_i,
    input  logic                rx_valid_i,
    input  logic [7:0]          rx_byte_i,
    input  logic                tx_req_i,
    output logic [7:0]          tx_byte_o,
    output logic                lms_wr_en_o,
    output logic [3:0]          lms_wr_addr_o,
    output logic [7:0]          lms_wr_data_o,
    output logic [63:0]         slice_data_o,
    output logic                slice_start_o,
    input  logic                dec_busy_i,
    input  logic                sample_valid_i,
    input  logic [SAMPLE_W-1:0] sample_i,
    output logic                sample_hold_o,
    output logic                err_o
);

    localparam int CNT_W  = $clog2(LMS_BYTES + 1);
    localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;

    qoa_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;
    logic                lms_wr_en_q, lms_wr_en_d;
    logic [3:0]          lms_wr_addr_q, lms_wr_addr_d;
    logic [7:0]          lms_wr_data_q, lms_wr_data_d;
    logic [63:0]         slice_data_q, slice_data_d;
    logic                slice_start_q, slice_start_d;
    logic                phase_q, phase_d;
    logic [7:0]          tx_byte_q, tx_byte_d;
    logic                cs_q;
    logic                cs_fall;

    logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [SAMPLE_W-1:0] fifo_dout;
    logic [FCNT_W-1:0]   fifo_count;
    logic [3:0]          cnt_sat;

    assign cs_fall       = cs_q && !cs_active_i;
    assign fifo_push     = sample_valid_i && !fifo_full;
    // Second byte of the head has been taken: the sample is fully sent
    assign fifo_pop      = tx_req_i && !fifo_empty && phase_q;
    assign sample_hold_o = (fifo_count == FCNT_W'(FIFO_DEPTH));
    assign cnt_sat       = (cnt_q > CNT_W'(15)) ? 4'hF : cnt_q[3:0];

    qoa_sample_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .din_i   (sample_i),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Command parser: opcode decode, LMS byte writes, slice assembly and decoder start
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        err_d         = err_q;
        lms_wr_en_d   = 1'b0;
        lms_wr_addr_d = lms_wr_addr_q;
        lms_wr_data_d = lms_wr_data_q;
        slice_data_d  = slice_data_q;
        slice_start_d = 1'b0;
        if (cs_fall && (state_q == ST_LMS || state_q == ST_SLICE)) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_valid_i) begin
                        cnt_d = '0;
                        case (rx_byte_i)
                            OP_NOP:  ;
                            OP_LMS:  state_d = ST_LMS;
                            OP_DEC:  state_d = ST_SLICE;
                            OP_CLR:  err_d = 1'b0;
                            default: err_d = 1'b1;
                        endcase
                    end
                end
                ST_LMS: begin
                    if (rx_valid_i) begin
                        lms_wr_en_d   = 1'b1;
                        lms_wr_addr_d = cnt_q[3:0];
                        lms_wr_data_d = rx_byte_i;
                        if (cnt_q == CNT_W'(LMS_BYTES - 1)) begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_SLICE: begin
                    if (rx_valid_i) begin
                        slice_data_d = {slice_data_q[55:0], rx_byte_i};
                        if (cnt_q == CNT_W'(SLICE_BYTES - 1)) begin
                            state_d = ST_START;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_START: begin
                    if (!dec_busy_i) begin
                        slice_start_d = 1'b1;
                        state_d       = ST_IDLE;
                    end else if (rx_valid_i) begin
                        err_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
            if (cs_fall) cnt_d = '0;
        end
    end

    // TX scheduler: byte phase within the head sample and next byte to present
    always_comb begin
        phase_d = phase_q;
        if (cs_fall || fifo_empty) begin
            phase_d = 1'b0;
        end else if (tx_req_i) begin
            phase_d = !phase_q;
        end
        if (!fifo_empty) begin
            tx_byte_d = phase_q ? fifo_dout[7:0] : fifo_dout[15:8];
        end else begin
            tx_byte_d = {STATUS_MARKER, dec_busy_i, err_q, (state_q != ST_IDLE), cnt_sat};
        end
    end

    // State and registered outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            err_q         <= 1'b0;
            lms_wr_en_q   <= 1'b0;
            lms_wr_addr_q <= '0;
            lms_wr_data_q <= '0;
            slice_data_q  <= '0;
            slice_start_q <= 1'b0;
            phase_q       <= 1'b0;
            tx_byte_q     <= {STATUS_MARKER, 7'b0};
            cs_q          <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            err_q         <= err_d;
            lms_wr_en_q   <= lms_wr_en_d;
            lms_wr_addr_q <= lms_wr_addr_d;
            lms_wr_data_q <= lms_wr_data_d;
            slice_data_q  <= slice_data_d;
            slice_start_q <= slice_start_d;
            phase_q       <= phase_d;
            tx_byte_q     <= tx_byte_d;
            cs_q          <= cs_active_i;
        end
    end

    assign tx_byte_o     = tx_byte_q;
    assign lms_wr_en_o   = lms_wr_en_q;
    assign lms_wr_addr_o = lms_wr_addr_q;
    assign lms_wr_data_o = lms_wr_data_q;
    assign slice_data_o  = slice_data_q;
    assign slice_start_o = slice_start_q;
    assign err_o         = err_q;

endmodule
